// File: rtl/ddr3_pkg.sv
// Shared constants and types for the MIG 7-series UI request bridge.
package ddr3_pkg;

  // MIG UI command encodings driven on app_cmd.
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // One 512-bit UI beat spans eight UI addresses, so beat addresses are
  // always aligned to this step.
  localparam int UI_ADDR_STEP = 8;

  // Bridge control state: waiting for a request, or driving one to the MIG.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } bridge_state_t;

endpackage

// File: rtl/ddr3_rd_fifo.sv
// First-word-fall-through FIFO holding MIG read data until the consumer
// takes it. Pushes while full and pops while empty are ignored; the owner
// decides what a dropped push means.
module ddr3_rd_fifo #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Head entry falls through; forced to zero when empty so the output is
  // defined even though the storage itself is never cleared.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Advance read/write pointers on accepted pushes and pops.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Write the incoming beat into the slot addressed by the write pointer.
  // NOTE: the storage array has no reset; validity is tracked entirely by
  // the pointers, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ddr3_app_bridge.sv
// Adapts a single-beat valid/ready request port to the MIG 7-series user
// interface. Command and write-data handshakes are tracked independently;
// read data returns in order through a FIFO whose depth is also the pool of
// read credits, so the non-backpressurable MIG read path cannot overflow it.
module ddr3_app_bridge
  import ddr3_pkg::*;
#(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 512,
  parameter int MASK_W   = 64,
  parameter int RD_DEPTH = 16
) (
  input  logic              ui_clk,
  input  logic              reset,
  input  logic              init_calib_complete,
  // Request port
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  // Read response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  // MIG command channel
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  // MIG write-data channel
  output logic [DATA_W-1:0] app_wdf_data,
  output logic [MASK_W-1:0] app_wdf_mask,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  // MIG read-data channel
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  // Status
  output logic              busy,
  output logic              err_overflow
);

  localparam int CW = $clog2(RD_DEPTH) + 1;

  bridge_state_t     r_state;
  bridge_state_t     w_state_nxt;
  logic              r_cmd_pend;
  logic              w_cmd_pend_nxt;
  logic              r_data_pend;
  logic              w_data_pend_nxt;
  logic [CW-1:0]     r_credits;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_cmd;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic              r_err_overflow;

  logic              w_accept;
  logic              w_rd_accept;
  logic              w_rsp_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  // A request is taken only while idle, calibrated and holding a credit.
  // Writes need no credit, but the same rule keeps req_ready independent
  // of the request contents.
  assign req_ready   = (r_state == ST_IDLE) && init_calib_complete &&
                       (r_credits != '0);
  assign w_accept    = req_valid && req_ready;
  assign w_rd_accept = w_accept && !req_write;
  assign w_rsp_pop   = rsp_valid && rsp_ready;

  // The UI outputs come straight from registers, so they are glitch-free
  // and stay stable for as long as their handshake is pending.
  assign app_en       = r_cmd_pend;
  assign app_addr     = r_addr;
  assign app_cmd      = r_cmd;
  assign app_wdf_data = r_wdata;
  assign app_wdf_mask = r_wmask;
  assign app_wdf_wren = r_data_pend;
  assign app_wdf_end  = r_data_pend;

  assign rsp_valid    = !w_fifo_empty;
  assign busy         = (r_state == ST_ISSUE) || (r_credits != CW'(RD_DEPTH));
  assign err_overflow = r_err_overflow;

  // Next-state logic: capture in IDLE, retire each channel on its own
  // handshake in ISSUE, and return to IDLE on the edge the last one clears.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_pend_nxt  = r_cmd_pend;
    w_data_pend_nxt = r_data_pend;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt     = ST_ISSUE;
          w_cmd_pend_nxt  = 1'b1;
          w_data_pend_nxt = req_write;
        end
      end
      ST_ISSUE: begin
        if (r_cmd_pend && app_rdy)       w_cmd_pend_nxt  = 1'b0;
        if (r_data_pend && app_wdf_rdy)  w_data_pend_nxt = 1'b0;
        if (!w_cmd_pend_nxt && !w_data_pend_nxt) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_cmd_pend_nxt  = 1'b0;
        w_data_pend_nxt = 1'b0;
      end
    endcase
  end

  // State and channel-pending flags; reset discards any request in flight.
  always_ff @(posedge ui_clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cmd_pend  <= 1'b0;
      r_data_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_pend  <= w_cmd_pend_nxt;
      r_data_pend <= w_data_pend_nxt;
    end
  end

  // Capture the accepted request; the address is aligned down to a beat.
  always_ff @(posedge ui_clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_cmd   <= CMD_WRITE;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_accept) begin
      r_addr  <= req_addr & ~ADDR_W'(UI_ADDR_STEP - 1);
      r_cmd   <= req_write ? CMD_WRITE : CMD_READ;
      r_wdata <= req_wdata;
      r_wmask <= req_wmask;
    end
  end

  // Read credits: one is taken per accepted read and returned per response
  // consumed, so reads in flight plus buffered data never exceed the FIFO.
  always_ff @(posedge ui_clk or posedge reset) begin
    if (reset) begin
      r_credits <= CW'(RD_DEPTH);
    end else begin
      case ({w_rd_accept, w_rsp_pop})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Sticky flag for read data arriving with nowhere to go.
  always_ff @(posedge ui_clk or posedge reset) begin
    if (reset) begin
      r_err_overflow <= 1'b0;
    end else if (app_rd_data_valid && w_fifo_full) begin
      r_err_overflow <= 1'b1;
    end
  end

  ddr3_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RD_DEPTH)
  ) u_rd_fifo (
    .i_clk   (ui_clk),
    .i_rst   (reset),
    .i_push  (app_rd_data_valid),
    .i_data  (app_rd_data),
    .i_pop   (w_rsp_pop),
    .o_data  (rsp_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_ddr3_app_bridge.sv
// Self-checking bench for ddr3_app_bridge. Stimulus changes 1 time unit
// after the rising edge; the monitor and the scenario tasks observe on the
// falling edge. Commands, write data and read responses are predicted into
// queues when stimulus is driven and compared when the bridge produces them.
module tb_ddr3_app_bridge;
  import ddr3_pkg::*;

  localparam int ADDR_W   = 30;
  localparam int DATA_W   = 512;
  localparam int MASK_W   = 64;
  localparam int RD_DEPTH = 16;

  logic              ui_clk = 1'b0;
  logic              reset;
  logic              init_calib_complete;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              busy;
  logic              err_overflow;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
  } cmd_exp_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } wd_exp_t;

  cmd_exp_t          q_cmd[$];
  wd_exp_t           q_wd[$];
  logic [DATA_W-1:0] q_rsp[$];

  always #5 ui_clk = ~ui_clk;

  ddr3_app_bridge #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MASK_W   (MASK_W),
    .RD_DEPTH (RD_DEPTH)
  ) dut (
    .ui_clk              (ui_clk),
    .reset               (reset),
    .init_calib_complete (init_calib_complete),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .req_wmask           (req_wmask),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .busy                (busy),
    .err_overflow        (err_overflow)
  );

  // Scoreboard monitor: predicts on request accept / read-data arrival,
  // compares on UI handshakes and response pops.
  always @(negedge ui_clk) begin : mon
    int                sz;
    cmd_exp_t          ec;
    wd_exp_t           ew;
    logic [DATA_W-1:0] er;
    if (reset) begin
      q_cmd.delete();
      q_wd.delete();
      q_rsp.delete();
    end else begin
      sz = q_rsp.size();
      if (req_valid && req_ready) begin
        ec.cmd  = req_write ? 3'b000 : 3'b001;
        ec.addr = req_addr & ~30'h7;
        q_cmd.push_back(ec);
        if (req_write) begin
          ew.data = req_wdata;
          ew.mask = req_wmask;
          q_wd.push_back(ew);
        end
      end
      if (app_en && app_rdy) begin
        checks++;
        if (q_cmd.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got cmd=%b addr=%h, required no command", app_cmd, app_addr);
        end else begin
          ec = q_cmd.pop_front();
          if (app_cmd !== ec.cmd || app_addr !== ec.addr) begin
            errors++;
            $display("FAIL cmd_match: got cmd=%b addr=%h, required cmd=%b addr=%h",
                     app_cmd, app_addr, ec.cmd, ec.addr);
          end
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        checks++;
        if (q_wd.size() == 0) begin
          errors++;
          $display("FAIL wdata_unexpected: got wren with no write pending");
        end else begin
          ew = q_wd.pop_front();
          if (app_wdf_data !== ew.data || app_wdf_mask !== ew.mask || app_wdf_end !== 1'b1) begin
            errors++;
            $display("FAIL wdata_match: got data=%h mask=%h end=%b, required data=%h mask=%h end=1",
                     app_wdf_data, app_wdf_mask, app_wdf_end, ew.data, ew.mask);
          end
        end
      end
      checks++;
      if (rsp_valid !== (sz != 0)) begin
        errors++;
        $display("FAIL rsp_valid: got %b, required %b", rsp_valid, (sz != 0));
      end
      if (rsp_valid && rsp_ready && sz != 0) begin
        er = q_rsp.pop_front();
        checks++;
        if (rsp_data !== er) begin
          errors++;
          $display("FAIL rsp_data: got %h, required %h", rsp_data, er);
        end
      end
      if (app_rd_data_valid && sz < RD_DEPTH) q_rsp.push_back(app_rd_data);
    end
  end

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic step();
    @(posedge ui_clk);
    #1;
  endtask

  // Offer one request and hold it until accepted (bounded).
  task automatic send_req(input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    bit done;
    done      = 1'b0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge ui_clk);
      if (req_ready) done = 1'b1;
      step();
    end
    req_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_req_timeout: got no accept for addr=%h, required accept within 50 cycles", a);
    end
  endtask

  task automatic inject_rd(input logic [DATA_W-1:0] d);
    app_rd_data       = d;
    app_rd_data_valid = 1'b1;
    step();
    app_rd_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    init_calib_complete = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    rsp_ready = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data = '0; app_rd_data_valid = 1'b0;
    repeat (3) step();
    @(negedge ui_clk);
    checks++;
    if ({req_ready, rsp_valid, app_en, app_wdf_wren, app_wdf_end, busy, err_overflow} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got rdy=%b rv=%b en=%b wren=%b end=%b busy=%b ovf=%b, required all 0",
               req_ready, rsp_valid, app_en, app_wdf_wren, app_wdf_end, busy, err_overflow);
    end
    checks++;
    if (app_addr !== '0 || app_cmd !== 3'b000 || rsp_data !== '0 ||
        app_wdf_data !== '0 || app_wdf_mask !== '0) begin
      errors++;
      $display("FAIL reset_buses: got addr=%h cmd=%b, required addr=0 cmd=000 and zero data", app_addr, app_cmd);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_uncalibrated: got %b, required 0", req_ready);
    end
    init_calib_complete = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_calibrated: got %b, required 1", req_ready);
    end
    step();
  endtask

  task automatic test_single_write();
    int en_cnt;
    int wr_cnt;
    en_cnt = 0;
    wr_cnt = 0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    send_req(1'b1, 30'h1000, {16{32'hA5A5A5A5}}, 64'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge ui_clk);
      if (k == 1) begin
        checks++;
        if (app_cmd !== CMD_WRITE || app_addr !== 30'h1000) begin
          errors++;
          $display("FAIL single_write_cmd: got cmd=%b addr=%h, required 000 and 1000", app_cmd, app_addr);
        end
      end
      if (app_en) en_cnt++;
      if (app_wdf_wren) wr_cnt++;
      step();
    end
    checks++;
    if (en_cnt != 1 || wr_cnt != 1) begin
      errors++;
      $display("FAIL single_write_pulses: got en=%0d wren=%0d cycles, required 1 and 1", en_cnt, wr_cnt);
    end
  endtask

  task automatic test_stall();
    int en_cnt;
    int wr_cnt;
    int first_ready;
    en_cnt = 0;
    wr_cnt = 0;
    first_ready = 0;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    send_req(1'b1, 30'h2440, rand_data(), 64'hF0F0_0000_0000_00FF);
    for (int k = 1; k <= 10; k++) begin
      app_rdy     = (k >= 6);
      app_wdf_rdy = (k >= 3);
      @(negedge ui_clk);
      if (app_en) en_cnt++;
      if (app_wdf_wren) wr_cnt++;
      if (req_ready && first_ready == 0) first_ready = k;
      if (k == 6) begin
        checks++;
        if (app_addr !== 30'h2440 || app_cmd !== CMD_WRITE) begin
          errors++;
          $display("FAIL stall_cmd_stable: got addr=%h cmd=%b, required 2440 and 000", app_addr, app_cmd);
        end
      end
      step();
    end
    checks++;
    if (en_cnt != 6 || wr_cnt != 3) begin
      errors++;
      $display("FAIL stall_pulses: got en=%0d wren=%0d cycles, required 6 and 3", en_cnt, wr_cnt);
    end
    checks++;
    if (first_ready != 7) begin
      errors++;
      $display("FAIL stall_ready_return: got cycle %0d, required 7", first_ready);
    end
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
  endtask

  task automatic test_credits();
    rsp_ready = 1'b0;
    for (int i = 0; i < RD_DEPTH; i++) send_req(1'b0, ADDR_W'(i * 8 + 'h4000), '0, '0);
    repeat (3) step();
    @(negedge ui_clk);
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL credits_exhausted: got ready=%b busy=%b, required 0 and 1", req_ready, busy);
    end
    step();
    for (int i = 0; i < RD_DEPTH; i++) inject_rd(rand_data());
    @(negedge ui_clk);
    checks++;
    if (err_overflow !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL credits_fill: got ovf=%b rv=%b, required 0 and 1", err_overflow, rsp_valid);
    end
    step();
  endtask

  task automatic test_overflow();
    inject_rd({16{32'hDEADBEEF}});
    @(negedge ui_clk);
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got %b, required 1", err_overflow);
    end
    repeat (3) step();
    @(negedge ui_clk);
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_hold: got %b, required 1", err_overflow);
    end
    step();
  endtask

  task automatic test_drain();
    bit empty_seen;
    empty_seen = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    @(negedge ui_clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_pop_credit: got ready=%b, required 1", req_ready);
    end
    step();
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && !empty_seen; i++) begin
      @(negedge ui_clk);
      if (!rsp_valid) empty_seen = 1'b1;
      step();
    end
    rsp_ready = 1'b0;
    @(negedge ui_clk);
    checks++;
    if (!empty_seen || busy !== 1'b0 || err_overflow !== 1'b1) begin
      errors++;
      $display("FAIL drain_done: got empty=%b busy=%b ovf=%b, required 1, 0, 1", empty_seen, busy, err_overflow);
    end
    step();
  endtask

  task automatic test_addr_align();
    send_req(1'b1, 30'h1007, rand_data(), 64'h0123_4567_89AB_CDEF);
    @(negedge ui_clk);
    checks++;
    if (app_addr !== 30'h1000) begin
      errors++;
      $display("FAIL align_write: got addr=%h, required 1000", app_addr);
    end
    step();
    send_req(1'b0, 30'h2005, '0, '0);
    @(negedge ui_clk);
    checks++;
    if (app_addr !== 30'h2000 || app_cmd !== CMD_READ || app_wdf_wren !== 1'b0) begin
      errors++;
      $display("FAIL align_read: got addr=%h cmd=%b wren=%b, required 2000, 001, 0", app_addr, app_cmd, app_wdf_wren);
    end
    step();
    inject_rd(rand_data());
    rsp_ready = 1'b1;
    repeat (3) step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc_cyc[4];
    int count;
    int cyc;
    count = 0;
    cyc = 0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 30'h8000;
    req_wdata = rand_data();
    req_wmask = 64'h0;
    for (int i = 0; i < 40 && count < 4; i++) begin
      @(negedge ui_clk);
      if (req_ready) begin
        acc_cyc[count] = cyc;
        count++;
        step();
        req_addr  = req_addr + 30'h8;
        req_wdata = rand_data();
        req_wmask = {$urandom, $urandom};
      end else begin
        step();
      end
      cyc++;
    end
    req_valid = 1'b0;
    checks++;
    if (count != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d accepts, required 4", count);
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 2) begin
          errors++;
          $display("FAIL b2b_spacing: got %0d cycles between accepts, required 2", acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    repeat (3) step();
  endtask

  task automatic test_calib_loss();
    app_rdy = 1'b0;
    send_req(1'b0, 30'h3000, '0, '0);
    init_calib_complete = 1'b0;
    step();
    app_rdy = 1'b1;
    repeat (2) step();
    @(negedge ui_clk);
    checks++;
    if (req_ready !== 1'b0 || app_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL calib_loss: got ready=%b en=%b busy=%b, required 0, 0, 1", req_ready, app_en, busy);
    end
    step();
    init_calib_complete = 1'b1;
    inject_rd(rand_data());
    rsp_ready = 1'b1;
    repeat (3) step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    app_rdy = 1'b1;
    send_req(1'b0, 30'h40, '0, '0);
    step();
    inject_rd(rand_data());
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    send_req(1'b1, 30'h5000, rand_data(), 64'h0);
    @(negedge ui_clk);
    checks++;
    if (app_en !== 1'b1 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got en=%b rv=%b, required 1 and 1", app_en, rsp_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (app_en !== 1'b0 || app_wdf_wren !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got en=%b wren=%b, required 0 and 0", app_en, app_wdf_wren);
    end
    repeat (2) step();
    reset = 1'b0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    @(negedge ui_clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: got rv=%b busy=%b ready=%b ovf=%b, required 0, 0, 1, 0",
               rsp_valid, busy, req_ready, err_overflow);
    end
    step();
    send_req(1'b1, 30'h6008, rand_data(), 64'hFF);
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_stall();
    test_credits();
    test_overflow();
    test_drain();
    test_addr_align();
    test_back_to_back();
    test_calib_loss();
    test_reset_mid();
    @(negedge ui_clk);
    checks++;
    if (q_cmd.size() != 0 || q_wd.size() != 0 || q_rsp.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got cmd=%0d wd=%0d rsp=%0d pending, required 0",
               q_cmd.size(), q_wd.size(), q_rsp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ddr3_app_bridge.md
# ddr3_app_bridge

Request/response adapter between the test sequencers and the `mig_7series_0` user interface (UI). It accepts single-beat read and write requests on a valid/ready port and drives the MIG `app_*` command and write-data channels. The command and write-data handshakes (`app_rdy`, `app_wdf_rdy`) are tracked independently. Read data returns in order through a credit-protected response FIFO, so the MIG read path, which has no backpressure, can never overflow.

## Interface
Parameters:
- `ADDR_W`, 30, width of `app_addr` and `req_addr`
- `DATA_W`, 512, UI data width
- `MASK_W`, 64, byte-mask width (`DATA_W/8`)
- `RD_DEPTH`, 16, response FIFO depth and the read-credit pool; power of two, at least 2

Ports:
- `ui_clk`  in  1  MIG UI clock; the only clock
- `reset`  in  1  reset; **one clock; reset is asynchronous and active-high**
- `init_calib_complete`  in  1  MIG calibration done
- `req_valid`  in  1  request offered
- `req_ready`  out  1  request accepted when high together with `req_valid`
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  `ADDR_W`  UI address
- `req_wdata`  in  `DATA_W`  write data
- `req_wmask`  in  `MASK_W`  write mask; 1 = byte masked
- `rsp_valid`  out  1  read data available
- `rsp_ready`  in  1  consumer accepts read data
- `rsp_data`  out  `DATA_W`  read data, in request order
- `app_addr`  out  `ADDR_W`  to MIG
- `app_cmd`  out  3  to MIG; 000 = write, 001 = read
- `app_en`  out  1  to MIG
- `app_rdy`  in  1  from MIG
- `app_wdf_data`  out  `DATA_W`  to MIG
- `app_wdf_mask`  out  `MASK_W`  to MIG
- `app_wdf_wren`  out  1  to MIG
- `app_wdf_end`  out  1  to MIG
- `app_wdf_rdy`  in  1  from MIG
- `app_rd_data`  in  `DATA_W`  from MIG
- `app_rd_data_valid`  in  1  from MIG
- `busy`  out  1  a command is pending or reads are outstanding
- `err_overflow`  out  1  sticky; `app_rd_data_valid` arrived while the FIFO was full

## Operation
- **States:** `IDLE` and `ISSUE`.
- **`req_ready` rule:** `req_ready = (state==IDLE) && init_calib_complete && (credits != 0)`. It never depends on `req_valid` or `req_write`.
- **Capture (IDLE):**
  - On `req_valid && req_ready`, register cmd, address, data and mask, then go to `ISSUE`.
  - `app_addr` is `{req_addr[ADDR_W-1:3], 3'b000}`; the low 3 bits are forced to 0 (8-address stride per 512-bit beat).
  - Set `cmd_pend=1`.
  - Set `data_pend=req_write`.
- **ISSUE, command channel:**
  - `app_en = cmd_pend`.
  - `cmd_pend` clears on a cycle with `app_en && app_rdy`.
- **ISSUE, write-data channel:**
  - `app_wdf_wren = app_wdf_end = data_pend`.
  - `data_pend` clears on a cycle with `app_wdf_wren && app_wdf_rdy`.
  - The two channels complete in any order or on the same cycle.
- **Leaving ISSUE:** the cycle after both flags are 0 (or on the clearing edge itself), state returns to `IDLE`.
- **Credits:**
  - Reset to `RD_DEPTH`.
  - −1 on accepted read request; +1 on `rsp_valid && rsp_ready`; both on the same cycle leaves the count unchanged.
  - Writes do not consume credits.
- **Response FIFO:**
  - Pushes `app_rd_data` on `app_rd_data_valid`.
  - First-word-fall-through to `rsp_*`.
  - A push while full is dropped and sets `err_overflow`, which holds until reset.
- **`busy`:** `(state==ISSUE) || (credits != RD_DEPTH)`.
- **Calibration loss:** if `init_calib_complete` falls, `req_ready` drops; an in-flight ISSUE still completes.

## Timing
- **Reset values:** all outputs 0 (`app_cmd=000`, `app_addr=0`); credits = `RD_DEPTH`; state `IDLE`; FIFO empty.
- **Reset mid-operation:** asynchronous; `app_en`/`app_wdf_wren` drop immediately; the pending request is discarded.
- **Command timing:**
  - Request accepted at edge N → `app_en` high from cycle N+1.
  - Held with stable `app_addr`/`app_cmd` until `app_rdy` is sampled high.
  - Minimum 1 cycle per channel; back-to-back requests every 2 cycles when the MIG is always ready.
- **Write data:** `app_wdf_data`/`app_wdf_mask` are stable while `app_wdf_wren` is high. Write data is never presented later than its command.
- **Read return:** `app_rd_data_valid` at cycle M → `rsp_valid` at M+1.

## Structure
- Package `ddr3_pkg`:
  - UI command constants `CMD_WRITE=3'b000`, `CMD_READ=3'b001`
  - bridge state enum
  - `UI_ADDR_STEP=8`
- Sub-module `ddr3_rd_fifo`: synchronous FWFT FIFO with `full`/`empty`.

## Test plan
- Reset, calibration high, a single write (addr 0x1000, data 0xA5…) with the MIG always ready → `app_en` and `app_wdf_wren` are each high for exactly 1 cycle; `app_cmd=000`; `app_addr=0x1000`.
- `app_rdy` held low for 5 cycles, `app_wdf_rdy` for 2 → data handshake completes first; `app_en` stays high 6 cycles; `req_ready` returns only after both handshakes.
- 16 reads with `rsp_ready=0` → `req_ready` is 0 after the 16th accept; read data arrives → 16 entries, no `err_overflow`; the first pop restores one credit.
- Read data injected into a full FIFO → `err_overflow=1` and sticky; FIFO contents unchanged.
- `req_addr=0x1007` → `app_addr=0x1000`.
- Reset asserted while `app_en` is high → `app_en=0` same cycle; credits = 16 and `rsp_valid=0` after release.
